// File: rtl/uint_seq_calculator_if.sv
`default_nettype none
// ============================================================================
// Module      : uint_seq_calculator_if
// Description : Operand/op-select request channel and result/flags response
//               channel of the sequential unsigned calculator, each with a
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface uint_seq_calculator_if #(
  parameter int WIDTH = 16
);
  // Request channel
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             add;
  logic             subtract;
  logic             divide;
  logic             multiply;
  // Response channel
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] remainder;
  logic             invalid_input;
  logic             div_by_zero;
  logic             overflow;

  // Operand source and result sink side
  modport master (
    output in_valid, a, b, add, subtract, divide, multiply, out_ready,
    input  in_ready, out_valid, result, remainder, invalid_input, div_by_zero, overflow
  );

  // Calculator side
  modport slave (
    input  in_valid, a, b, add, subtract, divide, multiply, out_ready,
    output in_ready, out_valid, result, remainder, invalid_input, div_by_zero, overflow
  );
endinterface
`default_nettype wire

// File: rtl/uint_seq_calculator.sv
`default_nettype none
// ============================================================================
// Module      : uint_seq_calculator
// Description : Handshaked unsigned calculator. Add/subtract finish in one
//               cycle; multiply (shift-add) and divide (restoring) take WIDTH
//               iterations. Results and flags are held until the sink takes
//               them.
// Revision    : 1.0 - initial release
// ============================================================================
module uint_seq_calculator #(
  parameter int WIDTH = 16
) (
  input  wire logic              clk,
  input  wire logic              rst,
  uint_seq_calculator_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_next;
  logic [CW-1:0]      r_cnt;

  // Iteration registers: multiplier path and divider path
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_divisor;

  // Registered response
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_inv;
  logic               r_dz;
  logic               r_ov;

  logic [3:0]         w_ops;
  logic               w_onehot;
  logic               w_accept;
  logic               w_div0;
  logic               w_last;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quot_next;

  assign w_ops    = {bus.add, bus.subtract, bus.divide, bus.multiply};
  assign w_onehot = $onehot(w_ops);
  assign w_accept = bus.in_valid && (r_state == S_IDLE);
  assign w_div0   = (bus.b == '0);
  assign w_last   = (r_cnt == CW'(1));
  assign w_sum    = {1'b0, bus.a} + {1'b0, bus.b};

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // One restoring step: bring in the next dividend bit; the partial remainder
  // is always below the divisor, so the difference fits in WIDTH bits
  assign w_shift     = {r_rem, r_quot[WIDTH-1]};
  assign w_ge        = (w_shift >= {1'b0, r_divisor});
  assign w_rem_next  = w_ge ? (w_shift[WIDTH-1:0] - r_divisor) : w_shift[WIDTH-1:0];
  assign w_quot_next = {r_quot[WIDTH-2:0], w_ge};

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_onehot)                  w_next = S_DONE;
          else if (bus.multiply)          w_next = S_MUL;
          else if (bus.divide && !w_div0) w_next = S_DIV;
          else                            w_next = S_DONE;
        end
      end
      S_MUL, S_DIV: begin
        if (w_last) w_next = S_DONE;
      end
      default: begin
        if (bus.out_ready) w_next = S_IDLE;
      end
    endcase
  end

  // Handshake outputs and registered response decoded from state
  always_comb begin
    bus.in_ready      = (r_state == S_IDLE);
    bus.out_valid     = (r_state == S_DONE);
    bus.result        = r_result;
    bus.remainder     = r_remainder;
    bus.invalid_input = r_inv;
    bus.div_by_zero   = r_dz;
    bus.overflow      = r_ov;
  end

  // Operand capture, iteration datapath and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_divisor   <= '0;
      r_result    <= '0;
      r_remainder <= '0;
      r_inv       <= 1'b0;
      r_dz        <= 1'b0;
      r_ov        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_inv       <= 1'b0;
            r_dz        <= 1'b0;
            r_ov        <= 1'b0;
            r_remainder <= '0;
            r_cnt       <= CW'(WIDTH);
            r_acc       <= '0;
            r_mcand     <= {{WIDTH{1'b0}}, bus.a};
            r_mplier    <= bus.b;
            r_quot      <= bus.a;
            r_rem       <= '0;
            r_divisor   <= bus.b;
            if (!w_onehot) begin
              r_inv    <= 1'b1;
              r_result <= '0;
            end else if (bus.add) begin
              r_result <= w_sum[WIDTH-1:0];
              r_ov     <= w_sum[WIDTH];
            end else if (bus.subtract) begin
              r_result <= bus.a - bus.b;
              r_ov     <= (bus.a < bus.b);
            end else if (bus.divide && w_div0) begin
              r_result    <= '1;
              r_remainder <= bus.a;
              r_dz        <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CW'(1);
          if (w_last) begin
            r_result <= w_acc_next[WIDTH-1:0];
            r_ov     <= |w_acc_next[2*WIDTH-1:WIDTH];
          end
        end
        S_DIV: begin
          r_rem  <= w_rem_next;
          r_quot <= w_quot_next;
          r_cnt  <= r_cnt - CW'(1);
          if (w_last) begin
            r_result    <= w_quot_next;
            r_remainder <= w_rem_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uint_seq_calculator.sv
`default_nettype none
// ============================================================================
// Module      : tb_uint_seq_calculator
// Description : Self-checking bench for uint_seq_calculator (WIDTH=16) with
//               an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uint_seq_calculator;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  uint_seq_calculator_if #(.WIDTH(W)) bus ();

  uint_seq_calculator #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic         inv;
    logic         dz;
    logic         ov;
  } resp_t;

  // Reference model; ops = {add, subtract, divide, multiply}
  function automatic void model(input logic [3:0] ops, input logic [W-1:0] a, input logic [W-1:0] b,
                                output resp_t r, output int lat);
    longint s;
    longint p;
    r   = '0;
    lat = 1;
    if ($countones(ops) != 1) begin
      r.inv = 1'b1;
    end else if (ops[3]) begin
      s    = longint'(a) + longint'(b);
      r.res = W'(s);
      r.ov  = (s >= 65536);
    end else if (ops[2]) begin
      s    = longint'(a) - longint'(b);
      r.res = W'(s);
      r.ov  = (s < 0);
    end else if (ops[1]) begin
      if (b == 0) begin
        r.res = '1;
        r.rem = a;
        r.dz  = 1'b1;
      end else begin
        r.res = a / b;
        r.rem = a % b;
        lat   = W + 1;
      end
    end else begin
      p    = longint'(a) * longint'(b);
      r.res = W'(p);
      r.ov  = (p >= 65536);
      lat   = W + 1;
    end
  endfunction

  // Issue one transaction from IDLE and collect its response; lat counts
  // cycles from the accept cycle to the first cycle with out_valid
  task automatic run_op(input logic [3:0] ops, input logic [W-1:0] a, input logic [W-1:0] b,
                        output resp_t r, output int lat);
    {bus.add, bus.subtract, bus.divide, bus.multiply} = ops;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    {bus.add, bus.subtract, bus.divide, bus.multiply} = 4'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r = {bus.result, bus.remainder, bus.invalid_input, bus.div_by_zero, bus.overflow};
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_handshake: in_ready/out_valid=%b required 10", {bus.in_ready, bus.out_valid});
    end
    checks++;
    if ({bus.result, bus.remainder, bus.invalid_input, bus.div_by_zero, bus.overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: res=%h rem=%h flags=%b required all zero", bus.result, bus.remainder,
               {bus.invalid_input, bus.div_by_zero, bus.overflow});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [3:0]   t_ops [12] = '{4'b1000, 4'b0100, 4'b0001, 4'b0010, 4'b0010, 4'b1001,
                                 4'b0000, 4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b1111};
    logic [W-1:0] t_a   [12] = '{16'hFFFF, 16'd3, 16'h0100, 16'd1000, 16'd9, 16'd5,
                                 16'd5, 16'd5, 16'hFFFF, 16'd0, 16'hFFFF, 16'd1};
    logic [W-1:0] t_b   [12] = '{16'h0002, 16'd5, 16'h0100, 16'd7, 16'd0, 16'd6,
                                 16'd6, 16'd9, 16'hFFFF, 16'd0, 16'd0, 16'd1};
    resp_t exp_r;
    resp_t got_r;
    int    exp_lat;
    int    got_lat;
    for (int i = 0; i < 12; i++) begin
      model(t_ops[i], t_a[i], t_b[i], exp_r, exp_lat);
      run_op(t_ops[i], t_a[i], t_b[i], got_r, got_lat);
      checks++;
      if (got_r !== exp_r) begin
        errors++;
        $display("FAIL directed_resp[%0d]: res=%h rem=%h flags=%b required res=%h rem=%h flags=%b", i,
                 got_r.res, got_r.rem, {got_r.inv, got_r.dz, got_r.ov},
                 exp_r.res, exp_r.rem, {exp_r.inv, exp_r.dz, exp_r.ov});
      end
      checks++;
      if (got_lat != exp_lat) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d required %0d", i, got_lat, exp_lat);
      end
      checks++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
        errors++;
        $display("FAIL directed_release[%0d]: in_ready/out_valid=%b required 10", i,
                 {bus.in_ready, bus.out_valid});
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]   ops;
    logic [W-1:0] a;
    logic [W-1:0] b;
    resp_t        exp_r;
    resp_t        got_r;
    int           exp_lat;
    int           got_lat;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) ops = 4'($urandom);
      else                           ops = 4'b0001 << $urandom_range(0, 3);
      a = W'($urandom);
      b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom >> $urandom_range(0, 16));
      model(ops, a, b, exp_r, exp_lat);
      run_op(ops, a, b, got_r, got_lat);
      checks++;
      if (got_r !== exp_r || got_lat != exp_lat) begin
        errors++;
        $display("FAIL random[%0d] ops=%b a=%h b=%h: res=%h rem=%h flags=%b lat=%0d required res=%h rem=%h flags=%b lat=%0d",
                 i, ops, a, b, got_r.res, got_r.rem, {got_r.inv, got_r.dz, got_r.ov}, got_lat,
                 exp_r.res, exp_r.rem, {exp_r.inv, exp_r.dz, exp_r.ov}, exp_lat);
      end
    end
  endtask

  task automatic test_backpressure();
    resp_t exp_r;
    resp_t snap;
    resp_t now_r;
    int    exp_lat;
    int    n;
    model(4'b1000, 16'h1234, 16'h0F0F, exp_r, exp_lat);
    {bus.add, bus.subtract, bus.divide, bus.multiply} = 4'b1000;
    bus.a        = 16'h1234;
    bus.b        = 16'h0F0F;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    snap = {bus.result, bus.remainder, bus.invalid_input, bus.div_by_zero, bus.overflow};
    checks++;
    if (snap !== exp_r || !bus.out_valid) begin
      errors++;
      $display("FAIL bp_result: out_valid=%b res=%h flags=%b required out_valid=1 res=%h flags=%b",
               bus.out_valid, snap.res, {snap.inv, snap.dz, snap.ov}, exp_r.res, {exp_r.inv, exp_r.dz, exp_r.ov});
    end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      {bus.add, bus.subtract, bus.divide, bus.multiply} = 4'b0001 << $urandom_range(0, 3);
      @(posedge clk); #1;
      now_r = {bus.result, bus.remainder, bus.invalid_input, bus.div_by_zero, bus.overflow};
      checks++;
      if (now_r !== snap || {bus.in_ready, bus.out_valid} !== 2'b01) begin
        errors++;
        $display("FAIL bp_hold[%0d]: in_ready/out_valid=%b res=%h required 01 res=%h", i,
                 {bus.in_ready, bus.out_valid}, now_r.res, snap.res);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    now_r = {bus.result, bus.remainder, bus.invalid_input, bus.div_by_zero, bus.overflow};
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10 || now_r !== snap) begin
      errors++;
      $display("FAIL bp_release: in_ready/out_valid=%b res=%h required 10 res=%h",
               {bus.in_ready, bus.out_valid}, now_r.res, snap.res);
    end
  endtask

  task automatic test_reset_mid_op();
    resp_t exp_r;
    resp_t got_r;
    int    exp_lat;
    int    got_lat;
    {bus.add, bus.subtract, bus.divide, bus.multiply} = 4'b0001;
    bus.a        = 16'h00FF;
    bus.b        = 16'h0101;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL midrst_handshake: in_ready/out_valid=%b required 10", {bus.in_ready, bus.out_valid});
    end
    checks++;
    if ({bus.result, bus.remainder, bus.invalid_input, bus.div_by_zero, bus.overflow} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: res=%h rem=%h flags=%b required all zero", bus.result, bus.remainder,
               {bus.invalid_input, bus.div_by_zero, bus.overflow});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    model(4'b1000, 16'h8000, 16'h8001, exp_r, exp_lat);
    run_op(4'b1000, 16'h8000, 16'h8001, got_r, got_lat);
    checks++;
    if (got_r !== exp_r || got_lat != exp_lat) begin
      errors++;
      $display("FAIL midrst_add: res=%h flags=%b lat=%0d required res=%h flags=%b lat=%0d",
               got_r.res, {got_r.inv, got_r.dz, got_r.ov}, got_lat,
               exp_r.res, {exp_r.inv, exp_r.dz, exp_r.ov}, exp_lat);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.add       = 1'b0;
    bus.subtract  = 1'b0;
    bus.divide    = 1'b0;
    bus.multiply  = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
